// File: rtl/regfile_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_pkg : shared defaults and typedefs for the multi-port register file
// Rev 1.0
// ----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_N_RD   = 2;
  localparam int XZR_IDX    = (1 << DEF_ADDR_W) - 1;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_scoreboard : busy bit per register, set by issue marks, cleared by
// writeback, with one raw busy lookup per read port.
// Rev 1.0
// ----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = DEF_N_RD,
  parameter int ZERO_IDX = XZR_IDX
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  input  logic                   mark_en,
  input  logic [ADDR_W-1:0]      mark_addr,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD-1:0]        busy_raw
);

  localparam int              DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Mark is applied after the clear so a same-address mark leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && (clr_addr != ZERO_A)) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (mark_en && (mark_addr != ZERO_A)) begin
      busy_d[mark_addr] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    busy_raw = '0;
    for (int k = 0; k < N_RD; k++) begin
      busy_raw[k] = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_mp : N_RD-read / 1-write register file with hard-wired zero register
// and busy-bit scoreboard. Define REGFILE_BYPASS_EN for write-to-read bypass.
// Rev 1.0
// ----------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = DEF_N_RD,
  parameter int ZERO_IDX = XZR_IDX
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_busy,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   mark_en,
  input  logic [ADDR_W-1:0]      mark_addr,
  output logic                   any_busy
);

  localparam int                DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [N_RD-1:0]   busy_raw;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .N_RD     (N_RD),
    .ZERO_IDX (ZERO_IDX)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .clr_en    (wr_en),
    .clr_addr  (wr_addr),
    .mark_en   (mark_en),
    .mark_addr (mark_addr),
    .rd_addr   (rd_addr),
    .busy_raw  (busy_raw)
  );

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != ZERO_A)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] addr;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < N_RD; k++) begin
      addr = rd_addr[k*ADDR_W +: ADDR_W];
      if (addr != ZERO_A) begin
        rd_data[k*DATA_W +: DATA_W] = regs_q[addr];
        rd_busy[k]                  = busy_raw[k];
`ifdef REGFILE_BYPASS_EN
        // A same-cycle mark of this register means a newer producer is in flight.
        if (wr_en && (wr_addr == addr)) begin
          rd_data[k*DATA_W +: DATA_W] = wr_data;
          rd_busy[k] = (mark_en && (mark_addr == addr)) ? busy_raw[k] : 1'b0;
        end
`endif
      end
    end
  end

  assign any_busy = |rd_busy;

endmodule : regfile_mp
`default_nettype wire
